// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations per back-end stage,
// stalls ID on unready operands and registers EXE forward selects.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int LAT_W = 2,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_fwd,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_regs,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic [LAT_W-1:0] id_lat,
  output logic             hazard_detected,
  output logic [SEL_W-1:0] val1_sel,
  output logic [SEL_W-1:0] val2_sel,
  output logic [SEL_W-1:0] src2_sel
);

  // WB never hazards or forwards, so only EXE..WB-1 are stored.
  localparam int N = DEPTH - 1;

  logic [N-1:0]     valid_q;
  logic [REG_W-1:0] dest_q [N];
  logic [LAT_W-1:0] lat_q  [N];

  logic             hit1;
  logic             hit2;
  logic             stall1;
  logic             stall2;
  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;
  logic             haz_raw;
  logic             bubble;
  logic             ins_valid;
  logic [LAT_W-1:0] lat_in;

  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    stall1 = 1'b0;
    stall2 = 1'b0;
    sel1   = '0;
    sel2   = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit1 && valid_q[i] && dest_q[i] == id_src1) begin
        hit1   = 1'b1;
        sel1   = SEL_W'(i + 1);
        stall1 = !en_fwd || ((i + 1) < int'(lat_q[i]));
      end
      if (!hit2 && valid_q[i] && dest_q[i] == id_src2) begin
        hit2   = 1'b1;
        sel2   = SEL_W'(i + 1);
        stall2 = !en_fwd || ((i + 1) < int'(lat_q[i]));
      end
    end
  end

  assign haz_raw         = stall1 || (id_two_regs && stall2);
  assign hazard_detected = haz_raw && !flush && !reset;
  assign bubble          = haz_raw || flush;
  assign ins_valid       = !bubble && id_wb_en && (id_dest != '0);

  always_comb begin
    lat_in = id_lat;
    if (id_lat == '0)
      lat_in = LAT_W'(1);
    else if (int'(id_lat) > DEPTH)
      lat_in = LAT_W'(DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      val1_sel <= '0;
      val2_sel <= '0;
      src2_sel <= '0;
    end else if (!mem_stall) begin
      for (int k = N - 1; k > 0; k--) begin
        valid_q[k] <= valid_q[k-1];
        dest_q[k]  <= dest_q[k-1];
        lat_q[k]   <= lat_q[k-1];
      end
      valid_q[0] <= ins_valid;
      dest_q[0]  <= id_dest;
      lat_q[0]   <= lat_in;
      if (bubble || !en_fwd) begin
        val1_sel <= '0;
        val2_sel <= '0;
        src2_sel <= '0;
      end else begin
        val1_sel <= sel1;
        src2_sel <= sel2;
        val2_sel <= id_two_regs ? sel2 : '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at DEPTH=3 and DEPTH=5,
// sharing one stimulus bus between both instances.
module tb_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       en_fwd;
  logic       mem_stall;
  logic       flush;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_regs;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic [1:0] lat3;
  logic [2:0] lat5;

  logic       haz3;
  logic [1:0] v1_3;
  logic [1:0] v2_3;
  logic [1:0] s2_3;
  logic       haz5;
  logic [2:0] v1_5;
  logic [2:0] v2_5;
  logic [2:0] s2_5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  hazard_scoreboard #(.DEPTH(3), .REG_W(5), .LAT_W(2)) dut3 (
    .clock(clock), .reset(reset), .en_fwd(en_fwd),
    .mem_stall(mem_stall), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_two_regs(id_two_regs), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_lat(lat3),
    .hazard_detected(haz3), .val1_sel(v1_3),
    .val2_sel(v2_3), .src2_sel(s2_3)
  );

  hazard_scoreboard #(.DEPTH(5), .REG_W(5), .LAT_W(3)) dut5 (
    .clock(clock), .reset(reset), .en_fwd(en_fwd),
    .mem_stall(mem_stall), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_two_regs(id_two_regs), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_lat(lat5),
    .hazard_detected(haz5), .val1_sel(v1_5),
    .val2_sel(v2_5), .src2_sel(s2_5)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input int s1, input int s2, input int two,
                        input int dst, input int wb, input int lat);
    id_src1     = 5'(s1);
    id_src2     = 5'(s2);
    id_two_regs = 1'(two);
    id_dest     = 5'(dst);
    id_wb_en    = 1'(wb);
    lat3        = 2'(lat);
    lat5        = 3'(lat);
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en_fwd    = 1'b1;
    mem_stall = 1'b0;
    flush     = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_haz3", haz3, 0);
    check("rst_v1_3", v1_3, 0);
    check("rst_v2_3", v2_3, 0);
    check("rst_s2_3", s2_3, 0);
    check("rst_v1_5", v1_5, 0);

    // ALU back-to-back
    set_id(0, 0, 0, 3, 1, 1);
    tick();
    set_id(3, 0, 0, 6, 1, 1);
    check("alu_haz", haz3, 0);
    tick();
    idle();
    check("alu_v1", v1_3, 1);
    check("alu_v2", v2_3, 0);

    // id_lat=0 behaves as ALU latency
    do_reset();
    set_id(0, 0, 0, 3, 1, 0);
    tick();
    set_id(3, 0, 0, 6, 1, 1);
    check("lat0_haz", haz3, 0);
    tick();
    idle();
    check("lat0_v1", v1_3, 1);

    // load-use
    do_reset();
    set_id(0, 0, 0, 4, 1, 2);
    tick();
    set_id(1, 4, 1, 7, 1, 1);
    check("lu_haz0", haz3, 1);
    tick();
    check("lu_haz1", haz3, 0);
    check("lu_bub_v2", v2_3, 0);
    tick();
    idle();
    check("lu_v2", v2_3, 2);
    check("lu_s2", s2_3, 2);
    check("lu_v1", v1_3, 0);

    // stall-only mode
    do_reset();
    en_fwd = 1'b0;
    set_id(0, 0, 0, 5, 1, 1);
    tick();
    set_id(5, 0, 0, 8, 1, 1);
    check("nf_haz0", haz3, 1);
    tick();
    check("nf_haz1", haz3, 1);
    tick();
    check("nf_haz2", haz3, 0);
    tick();
    idle();
    check("nf_v1", v1_3, 0);
    en_fwd = 1'b1;

    // r0 producer never matches
    do_reset();
    set_id(0, 0, 0, 0, 1, 2);
    tick();
    set_id(0, 0, 1, 9, 1, 1);
    check("r0_haz", haz3, 0);
    tick();
    check("r0_v1", v1_3, 0);
    check("r0_v2", v2_3, 0);
    check("r0_s2", s2_3, 0);

    // src2 ignored for hazard when two_regs=0
    do_reset();
    set_id(0, 0, 0, 6, 1, 2);
    tick();
    set_id(1, 6, 0, 9, 1, 1);
    check("tr_haz", haz3, 0);
    tick();
    idle();
    check("tr_v1", v1_3, 0);
    check("tr_v2", v2_3, 0);

    // flush during load-use stall
    do_reset();
    set_id(0, 0, 0, 4, 1, 2);
    tick();
    set_id(1, 4, 1, 7, 1, 1);
    flush = 1'b1;
    #1;
    check("fl_haz", haz3, 0);
    tick();
    flush = 1'b0;
    set_id(7, 0, 0, 10, 1, 1);
    check("fl_v2", v2_3, 0);
    check("fl_s2", s2_3, 0);
    check("fl_bub_haz", haz3, 0);
    tick();
    idle();
    check("fl_bub_v1", v1_3, 0);

    // mem_stall freezes a pending load-use, DEPTH=3
    do_reset();
    set_id(0, 0, 0, 4, 1, 2);
    tick();
    set_id(1, 4, 1, 7, 1, 1);
    check("ms_haz", haz3, 1);
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("ms_hold%0d", c), haz3, 1);
      check($sformatf("ms_v2_%0d", c), v2_3, 0);
    end
    mem_stall = 1'b0;
    #1;
    check("ms_rel", haz3, 1);
    tick();
    check("ms_go", haz3, 0);
    tick();
    idle();
    check("ms_v2", v2_3, 2);
    check("ms_s2", s2_3, 2);

    // DEPTH=5, latency 4, with a mem_stall in the middle
    do_reset();
    set_id(0, 0, 0, 4, 1, 4);
    tick();
    set_id(4, 0, 0, 7, 1, 1);
    check("d5_haz0", haz5, 1);
    mem_stall = 1'b1;
    tick();
    tick();
    check("d5_frz", haz5, 1);
    check("d5_frz_v1", v1_5, 0);
    mem_stall = 1'b0;
    #1;
    tick();
    check("d5_haz1", haz5, 1);
    tick();
    check("d5_haz2", haz5, 1);
    tick();
    check("d5_haz3", haz5, 0);
    tick();
    idle();
    check("d5_v1", v1_5, 4);

    // DEPTH=5, id_lat=7 clamps to 5: stall until WB, then regfile
    do_reset();
    set_id(0, 0, 0, 4, 1, 7);
    tick();
    set_id(4, 0, 0, 7, 1, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("cl_haz%0d", c), haz5, 1);
      tick();
    end
    check("cl_free", haz5, 0);
    tick();
    idle();
    check("cl_v1", v1_5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order integer pipeline.
- Replaces the fixed EXE/MEM-only hazard and forwarding pair with a scoreboard of in-flight destinations, one entry per back-end stage.
- Each entry carries a per-instruction result latency, so multi-cycle producers stall consumers for exactly the required cycles.
- Sits beside the ID stage: inspects the decoding instruction, drives the IF/ID freeze, and supplies registered operand-forward selects to EXE.

Parameters:
- DEPTH, 3, back-end stages tracked (entry 0 = EXE, 1 = MEM, ..., DEPTH-1 = WB); legal range 2..8.
- REG_W, 5, register-address width.
- LAT_W, 2, width of issue_lat; must hold DEPTH.
- SEL_W, $clog2(DEPTH), width of the forward selects.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- en_fwd  in  1  1 = forwarding enabled; 0 = stall-only mode.
- mem_stall  in  1  global freeze (memory wait); holds all state.
- flush  in  1  branch taken in EXE; ID instruction must not enter EXE.
- id_src1  in  REG_W  first source of the ID instruction.
- id_src2  in  REG_W  second source of the ID instruction.
- id_two_regs  in  1  id_src2 is a true register read.
- id_dest  in  REG_W  destination of the ID instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_lat  in  LAT_W  stage index at whose output the result becomes forwardable (ALU = 1, load = 2).
- hazard_detected  out  1  combinational stall; freezes PC and IF/ID.
- val1_sel  out  SEL_W  registered forward select for EXE operand 1 (0 = register file, k = stage k result).
- val2_sel  out  SEL_W  registered forward select for EXE operand 2 when two_regs.
- src2_sel  out  SEL_W  registered forward select for the store-data path.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- State per entry: valid, dest, lat. A match against an entry requires valid, wb_en at insert, and dest != 0.
- Hazard check: scan entries 0..DEPTH-2 for each active source (src1 always; src2 only when id_two_regs). The youngest (lowest-index) match i wins.
  - en_fwd=1: hazard if i+1 < lat(i).
  - en_fwd=0: hazard on any match.
  - A match in entry DEPTH-1 (WB) never hazards, because the register file writes before it is read.
- hazard_detected is combinational. It is forced 0 while flush=1, since the ID instruction is discarded anyway.
- Advance (mem_stall=0), every posedge:
  - entries shift k -> k+1; entry DEPTH-1 retires.
  - entry 0 loads the ID instruction unless hazard_detected or flush, in which case it loads a bubble (valid=0).
  - id_lat=0 is stored as 1; id_lat > DEPTH is clamped to DEPTH.
- Select registers, on the same advance edge:
  - with en_fwd=1 and no hazard, flush or bubble, val1_sel and src2_sel take (i+1) of the youngest src1 and src2 match respectively, or 0 if none.
  - val2_sel = src2_sel when id_two_regs, else 0.
  - on bubble, flush, or en_fwd=0, all three selects load 0.
- mem_stall=1: entries and select registers hold. hazard_detected is still computed from the held entries.
- Reset: all entries invalid; val1_sel, val2_sel and src2_sel = 0; hazard_detected = 0 while reset is high.
- Latency: stall is zero-cycle (same cycle). Selects are valid one cycle after the edge on which the consumer leaves ID.
- Simultaneous flush and hazard: the bubble is inserted and hazard_detected is 0.
- Simultaneous reset and mem_stall: reset wins.

Test Plan:
- ALU back-to-back, DEPTH=3, en_fwd=1: ADD r3 (lat 1) followed by SUB src1=r3 -> no stall; val1_sel=1 in the SUB EXE cycle.
- Load-use: LD r4 (lat 2) followed by ADD src2=r4, two_regs=1 -> hazard_detected=1 for one cycle and a bubble is inserted; next cycle no hazard; val2_sel=2 and src2_sel=2 in the ADD EXE cycle.
- Stall-only mode, en_fwd=0: ADD r5, then ADD using r5 -> hazard 2 cycles; consumer issues when the producer reaches WB; selects=0.
- r0 and two_regs rules: producer dest=0, or consumer src2 match with two_regs=0 -> no hazard, selects 0.
- Flush during hazard: load-use pair with flush=1 in the stall cycle -> hazard_detected=0; entry 0 becomes a bubble; selects 0.
- mem_stall: pending load-use with mem_stall held 3 cycles -> entries and selects frozen, hazard stays 1; resumes identically when released. Repeat with DEPTH=5, id_lat=4 -> 3 stall cycles, then sel=4.
